// File: rtl/viterbi_pkg.sv
// Shared types and default sizing for the tx/rx loopback blocks.
// The width helper keeps counter sizing consistent between the checker and its history buffer.
package viterbi_pkg;

    typedef enum logic [0:0] {
        BER_SEARCH = 1'b0,
        BER_LOCKED = 1'b1
    } ber_state_t;

    localparam int BER_MAX_LAT   = 64;
    localparam int BER_LOCK_LEN  = 32;
    localparam int BER_WIN       = 64;
    localparam int BER_LOSS_ERRS = 8;
    localparam int BER_CNT_W     = 32;
    localparam int BER_LAT_W     = $clog2(BER_MAX_LAT);

    // Bits needed to hold every value 0..max_val inclusive (never less than 1).
    function automatic int ber_cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ber_hist_sr.sv
// Reference-bit history: DEPTH-deep shift register, saturating fill count and
// a combinational read port hist[rd_idx] (hist[0] = most recent accepted bit).
module ber_hist_sr
    import viterbi_pkg::*;
#(
    parameter int DEPTH  = BER_MAX_LAT,
    parameter int IDX_W  = $clog2(DEPTH),
    parameter int FILL_W = ber_cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_en,
    input  logic              din,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_bit,
    output logic [FILL_W-1:0] fill
);

    logic [DEPTH-1:0] hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            fill   <= '0;
        end else if (shift_en) begin
            hist_q <= {hist_q[DEPTH-2:0], din};
            if (fill != FILL_W'(DEPTH)) begin
                fill <= fill + 1'b1;
            end
        end
    end

    // Reads the pre-shift contents, so a same-cycle shift is not visible here.
    assign rd_bit = hist_q[rd_idx];

endmodule

// File: rtl/viterbi_ber_checker.sv
// Finds the decoder latency by searching the reference history, then counts
// decoded bits and bit errors while locked, dropping lock on a bad window.
module viterbi_ber_checker
    import viterbi_pkg::*;
#(
    parameter int MAX_LAT   = BER_MAX_LAT,
    parameter int LOCK_LEN  = BER_LOCK_LEN,
    parameter int WIN       = BER_WIN,
    parameter int LOSS_ERRS = BER_LOSS_ERRS,
    parameter int CNT_W     = BER_CNT_W,
    parameter int LAT_W     = $clog2(MAX_LAT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ref_bit_i,
    input  logic             ref_valid_i,
    input  logic             dec_bit_i,
    input  logic             dec_valid_i,
    input  logic             clear_i,
    output logic             locked_o,
    output logic [LAT_W-1:0] latency_o,
    output logic [CNT_W-1:0] bit_ct_o,
    output logic [CNT_W-1:0] err_ct_o,
    output logic             lost_lock_o
);

    // Handshake: ref_valid_i / dec_valid_i are pure qualifiers with no backpressure;
    // the paired bit is consumed on every rising clk edge where its valid is high.

    localparam int FILL_W  = ber_cnt_w(MAX_LAT);
    localparam int MATCH_W = ber_cnt_w(LOCK_LEN);
    localparam int WCT_W   = ber_cnt_w(WIN - 1);
    localparam int WERR_W  = ber_cnt_w(LOSS_ERRS);

    ber_state_t         state_q, state_d;
    logic [LAT_W-1:0]   trial_q, latency_q;
    logic [MATCH_W-1:0] match_q;
    logic [WCT_W-1:0]   win_ct_q;
    logic [WERR_W-1:0]  win_err_q;
    logic [CNT_W-1:0]   bit_ct_q, err_ct_q, bit_ct_d, err_ct_d, bit_base, err_base;
    logic               lost_q;

    logic               exp_bit;
    logic [FILL_W-1:0]  fill;
    logic               cmp_en, mismatch, match_hit, lock_hit, loss_hit, win_wrap, count_en;
    logic [WERR_W:0]    win_sum;

    ber_hist_sr #(
        .DEPTH (MAX_LAT),
        .IDX_W (LAT_W),
        .FILL_W(FILL_W)
    ) u_hist (
        .clk     (clk),
        .rst     (rst),
        .shift_en(ref_valid_i),
        .din     (ref_bit_i),
        .rd_idx  (trial_q),
        .rd_bit  (exp_bit),
        .fill    (fill)
    );

    // A trial latency that reaches past the filled history cannot be judged yet.
    assign cmp_en    = dec_valid_i && (FILL_W'(trial_q) < fill);
    assign mismatch  = cmp_en && (dec_bit_i != exp_bit);
    assign match_hit = cmp_en && !mismatch;
    assign lock_hit  = (state_q == BER_SEARCH) && match_hit &&
                       (match_q == MATCH_W'(LOCK_LEN - 1));
    assign win_sum   = {1'b0, win_err_q} + {{WERR_W{1'b0}}, mismatch};
    assign loss_hit  = (state_q == BER_LOCKED) && cmp_en &&
                       (win_sum >= (WERR_W + 1)'(LOSS_ERRS));
    assign win_wrap  = (win_ct_q == WCT_W'(WIN - 1));
    assign count_en  = (state_q == BER_LOCKED) && cmp_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BER_SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BER_SEARCH: if (lock_hit) state_d = BER_LOCKED;
            BER_LOCKED: if (loss_hit) state_d = BER_SEARCH;
            default:    state_d = BER_SEARCH;
        endcase
    end

    always_comb begin
        locked_o    = (state_q == BER_LOCKED);
        latency_o   = latency_q;
        bit_ct_o    = bit_ct_q;
        err_ct_o    = err_ct_q;
        lost_lock_o = lost_q;
    end

    // Clear zeroes the base value first so a coincident compare still lands its increment.
    always_comb begin
        bit_base = clear_i ? '0 : bit_ct_q;
        err_base = clear_i ? '0 : err_ct_q;
        bit_ct_d = bit_base;
        err_ct_d = err_base;
        if (count_en && !(&bit_base)) begin
            bit_ct_d = bit_base + 1'b1;
        end
        if (count_en && mismatch && !(&err_base)) begin
            err_ct_d = err_base + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trial_q   <= '0;
            latency_q <= '0;
            match_q   <= '0;
            win_ct_q  <= '0;
            win_err_q <= '0;
            bit_ct_q  <= '0;
            err_ct_q  <= '0;
            lost_q    <= 1'b0;
        end else begin
            bit_ct_q <= bit_ct_d;
            err_ct_q <= err_ct_d;
            lost_q   <= loss_hit;
            if (state_q == BER_SEARCH) begin
                if (lock_hit) begin
                    latency_q <= trial_q;
                    match_q   <= '0;
                    win_ct_q  <= '0;
                    win_err_q <= '0;
                end else if (match_hit) begin
                    match_q <= match_q + 1'b1;
                end else if (mismatch) begin
                    match_q <= '0;
                    trial_q <= (trial_q == LAT_W'(MAX_LAT - 1)) ? '0 : trial_q + 1'b1;
                end
            end else if (cmp_en) begin
                // On loss the trial latency is kept so the search restarts where lock was.
                if (loss_hit) begin
                    match_q   <= '0;
                    win_ct_q  <= '0;
                    win_err_q <= '0;
                end else if (win_wrap) begin
                    win_ct_q  <= '0;
                    win_err_q <= '0;
                end else begin
                    win_ct_q  <= win_ct_q + 1'b1;
                    win_err_q <= win_err_q + WERR_W'(mismatch);
                end
            end
        end
    end

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Directed bench for viterbi_ber_checker: PRBS7 reference with a programmable decoder delay,
// expectations queued by the driver and checked by an independent negedge monitor.
module tb_viterbi_ber_checker;

    localparam int LAT_W   = 6;
    localparam int CNT_W   = 32;
    localparam int SAT_W   = 4;
    localparam int HIST_SZ = 8192;

    logic             clk = 1'b0;
    logic             rst, ref_bit, ref_valid, dec_bit, dec_valid, clear;
    logic             locked, lost_lock, s_locked, s_lost;
    logic [LAT_W-1:0] latency, s_latency;
    logic [CNT_W-1:0] bit_ct, err_ct;
    logic [SAT_W-1:0] s_bit_ct, s_err_ct;

    always #5 clk = ~clk;

    viterbi_ber_checker dut (
        .clk(clk), .rst(rst), .ref_bit_i(ref_bit), .ref_valid_i(ref_valid),
        .dec_bit_i(dec_bit), .dec_valid_i(dec_valid), .clear_i(clear),
        .locked_o(locked), .latency_o(latency), .bit_ct_o(bit_ct),
        .err_ct_o(err_ct), .lost_lock_o(lost_lock)
    );

    viterbi_ber_checker #(.CNT_W(SAT_W)) dut_sat (
        .clk(clk), .rst(rst), .ref_bit_i(ref_bit), .ref_valid_i(ref_valid),
        .dec_bit_i(dec_bit), .dec_valid_i(dec_valid), .clear_i(clear),
        .locked_o(s_locked), .latency_o(s_latency), .bit_ct_o(s_bit_ct),
        .err_ct_o(s_err_ct), .lost_lock_o(s_lost)
    );

    typedef struct {
        int               cyc;
        string            name;
        bit               chk_cnt;
        logic             lk;
        logic [LAT_W-1:0] lat;
        logic [CNT_W-1:0] bits;
        logic [CNT_W-1:0] errs;
        logic [SAT_W-1:0] sbits;
        logic [SAT_W-1:0] serrs;
        int               lost;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_m;
    int   n_vec = 0, n_mis = 0, cyc_ct = 0, lost_seen = 0, lost_seen_s = 0;
    bit   bad;

    logic [6:0] lfsr = 7'h7F;
    bit         sent[HIST_SZ];
    int         n_sent = 0, refs_since_rst = 0, delay = 0, since_lock = 0;
    bit         gate = 1'b1;

    // ---------------- clock/cycle bookkeeping and monitor ----------------
    always @(posedge clk) cyc_ct++;

    always @(negedge clk) begin
        if (lost_lock === 1'b1) lost_seen++;
        if (s_lost === 1'b1) lost_seen_s++;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_ct) begin
            e_m = exp_q.pop_front();
            bad = 1'b0;
            if (locked !== e_m.lk) begin
                $display("FAIL %s locked_o: got %0d want %0d", e_m.name, locked, e_m.lk); bad = 1'b1;
            end
            if (s_locked !== e_m.lk) begin
                $display("FAIL %s sat locked_o: got %0d want %0d", e_m.name, s_locked, e_m.lk); bad = 1'b1;
            end
            if (latency !== e_m.lat || s_latency !== e_m.lat) begin
                $display("FAIL %s latency_o: got %0d/%0d want %0d", e_m.name, latency, s_latency, e_m.lat); bad = 1'b1;
            end
            if (lost_seen != e_m.lost || lost_seen_s != e_m.lost) begin
                $display("FAIL %s lost_lock pulses: got %0d/%0d want %0d", e_m.name, lost_seen, lost_seen_s, e_m.lost); bad = 1'b1;
            end
            if (e_m.chk_cnt) begin
                if (bit_ct !== e_m.bits || err_ct !== e_m.errs) begin
                    $display("FAIL %s bit/err: got %0d/%0d want %0d/%0d", e_m.name, bit_ct, err_ct, e_m.bits, e_m.errs); bad = 1'b1;
                end
                if (s_bit_ct !== e_m.sbits || s_err_ct !== e_m.serrs) begin
                    $display("FAIL %s sat bit/err: got %0d/%0d want %0d/%0d", e_m.name, s_bit_ct, s_err_ct, e_m.sbits, e_m.serrs); bad = 1'b1;
                end
            end
            n_vec++;
            if (bad) n_mis++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input bit active, input bit flip, input bit clr, input bit do_rst, output bit did_cmp);
        bit d_en;
        d_en      = active && (!gate || refs_since_rst > delay) && (n_sent > delay);
        rst       = do_rst;
        clear     = clr;
        ref_valid = active;
        ref_bit   = active ? lfsr[6] : 1'b0;
        dec_valid = d_en;
        dec_bit   = d_en ? (sent[(n_sent - 1 - delay) % HIST_SZ] ^ flip) : 1'b0;
        if (active) begin
            sent[n_sent % HIST_SZ] = lfsr[6];
            n_sent++;
            refs_since_rst++;
            lfsr = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
        end
        if (do_rst) refs_since_rst = 0;
        did_cmp = d_en && !do_rst;
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmp(input int n, input int period);
        int k, guard;
        bit c;
        k = 0;
        guard = 0;
        while (k < n && guard < 4 * n + 100) begin
            issue(1'b1, (period > 0) && ((k % period) == period - 1), 1'b0, 1'b0, c);
            if (c) begin
                k++;
                since_lock++;
            end
            guard++;
        end
        if (k < n) begin
            n_vec++; n_mis++;
            $display("FAIL run_cmp: issued %0d compares want %0d", k, n);
        end
    endtask

    task automatic wait_lock(input string name, input int budget, input logic want);
        int k;
        bit c;
        k = 0;
        while (locked !== want && k < budget) begin
            issue(1'b1, 1'b0, 1'b0, 1'b0, c);
            k++;
        end
        if (locked !== want) begin
            n_vec++; n_mis++;
            $display("FAIL %s: locked_o got %0d want %0d within %0d cycles", name, locked, want, budget);
        end
        since_lock = 0;
    endtask

    task automatic expect_out(input string name, input bit chk_cnt, input logic lk, input int lat,
                              input int bits, input int errs, input int lost);
        exp_t e;
        e.cyc     = cyc_ct;
        e.name    = name;
        e.chk_cnt = chk_cnt;
        e.lk      = lk;
        e.lat     = LAT_W'(lat);
        e.bits    = CNT_W'(bits);
        e.errs    = CNT_W'(errs);
        e.sbits   = (bits > 15) ? 4'd15 : SAT_W'(bits);
        e.serrs   = (errs > 15) ? 4'd15 : SAT_W'(errs);
        e.lost    = lost;
        exp_q.push_back(e);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit c;
        rst = 1'b1; clear = 1'b0; ref_valid = 1'b0; ref_bit = 1'b0; dec_valid = 1'b0; dec_bit = 1'b0;
        issue(1'b0, 1'b0, 1'b0, 1'b1, c);
        issue(1'b0, 1'b0, 1'b0, 1'b1, c);
        expect_out("reset", 1'b1, 1'b0, 0, 0, 0, 0);

        // Clean stream at latency 23, then plain counting and saturation of the 4-bit build.
        delay = 23; gate = 1'b1;
        wait_lock("T1_lock", 400, 1'b1);
        expect_out("T1_lock", 1'b1, 1'b1, 23, 0, 0, 0);
        run_cmp(20, 0);
        expect_out("T1_count", 1'b1, 1'b1, 23, 20, 0, 0);
        issue(1'b1, 1'b1, 1'b1, 1'b0, c);
        if (c) since_lock++;
        expect_out("T5_clear_mis", 1'b1, 1'b1, 23, 1, 1, 0);
        issue(1'b0, 1'b0, 1'b1, 1'b0, c);
        expect_out("T5_clear", 1'b1, 1'b1, 23, 0, 0, 0);

        // Every 16th decoded bit flipped: 4 errors per window, lock must hold.
        run_cmp(1000, 16);
        expect_out("T2_sparse", 1'b1, 1'b1, 23, 1000, 62, 0);

        // Align to a window start, then a burst of 8 errors.
        while (since_lock % 64 != 0) run_cmp(1, 0);
        issue(1'b0, 1'b0, 1'b1, 1'b0, c);
        run_cmp(7, 1);
        expect_out("T3_7err", 1'b1, 1'b1, 23, 7, 7, 0);
        run_cmp(1, 1);
        expect_out("T3_loss", 1'b1, 1'b0, 23, 8, 8, 1);
        run_cmp(31, 0);
        expect_out("T3_search", 1'b1, 1'b0, 23, 8, 8, 1);
        run_cmp(1, 0);
        expect_out("T3_relock", 1'b1, 1'b1, 23, 8, 8, 1);
        run_cmp(10, 0);
        expect_out("T3_count", 1'b1, 1'b1, 23, 18, 8, 1);

        // Reset while locked with both valids high; decoded bits keep flowing so early compares skip.
        issue(1'b1, 1'b0, 1'b0, 1'b1, c);
        expect_out("T6_rst", 1'b1, 1'b0, 0, 0, 0, 1);
        gate = 1'b0;
        wait_lock("T6_relock", 600, 1'b1);
        expect_out("T6_relock", 1'b1, 1'b1, 23, 0, 0, 1);

        // Latency change to 5 forces loss; search runs 23..63, wraps, locks at 5.
        delay = 5;
        wait_lock("T4_loss", 300, 1'b0);
        wait_lock("T4_wrap", 800, 1'b1);
        expect_out("T4_wrap", 1'b0, 1'b1, 5, 0, 0, 2);

        issue(1'b0, 1'b0, 1'b0, 1'b1, c);
        delay = 63; gate = 1'b1;
        wait_lock("T4_lat63", 1200, 1'b1);
        expect_out("T4_lat63", 1'b1, 1'b1, 63, 0, 0, 2);

        // Latency 0: ref and dec valid together every cycle, exactly LOCK_LEN compares to lock.
        issue(1'b0, 1'b0, 1'b0, 1'b1, c);
        delay = 0;
        run_cmp(31, 0);
        expect_out("T4_l0_pre", 1'b1, 1'b0, 0, 0, 0, 2);
        run_cmp(1, 0);
        expect_out("T4_lat0", 1'b1, 1'b1, 0, 0, 0, 2);

        issue(1'b0, 1'b0, 1'b0, 1'b0, c);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_vec++; n_mis++;
            $display("FAIL drain: %0d expectations left unchecked", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
